// File: rtl/core_pkg.sv
// Shared encodings for the core sequencer: FSM states and trap cause codes.
package core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_FETCH_TO = 2'b01,
    CAUSE_DATA_TO  = 2'b10,
    CAUSE_ILLEGAL  = 2'b11
  } cause_t;

endpackage

// File: rtl/seq_watchdog.sv
// Memory-handshake watchdog: counts cycles a request waits unacknowledged and
// flags expiry on the cycle the count sits at MEM_TIMEOUT-1 with still no ack.
module seq_watchdog #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int W = $clog2(MEM_TIMEOUT) + 1;

  logic [W-1:0] cnt;

  assign expired = inc && (cnt == W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with trap handling.
// Optional perf counters are built when SEQ_PERF_CNT_EN is defined.
module core_sequencer
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             instr_we,
  output logic             decode_en,
  input  logic             illegal,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             writes_rd,
  input  logic [4:0]       dest,
  output logic             exec_en,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             pc_we,
  output logic             trap,
  output logic [1:0]       trap_cause,
  input  logic             trap_clr,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [2:0]       state_dbg
);

  state_t state;
  cause_t cause;
  logic   fetch_pend;
  logic   dmem_done;
  logic   wd_inc;
  logic   wd_clr;
  logic   wd_expired;

  // Handshake: req is the valid side, ack the ready side. A transfer completes
  // in the cycle both are high; once raised, req holds until that cycle and
  // only drops early on a watchdog trap or reset. Acks without a req are ignored.
  always_comb begin
    imem_req   = reset && (state == ST_FETCH) && (run || fetch_pend);
    instr_we   = imem_req && imem_ack;
    decode_en  = (state == ST_DECODE);
    exec_en    = (state == ST_EXEC);
    dmem_req   = (state == ST_MEM);
    dmem_we    = dmem_req && is_store;
    dmem_done  = dmem_req && dmem_ack;
    rf_we      = (state == ST_WB) && writes_rd && (dest != 5'd0);
    pc_we      = (state == ST_WB) || (dmem_done && is_store);
    trap       = (state == ST_TRAP);
    trap_cause = cause;
    state_dbg  = state;
    wd_inc     = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);
    wd_clr     = !wd_inc;
  end

  seq_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (wd_clr),
    .inc    (wd_inc),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_FETCH;
      cause      <= CAUSE_NONE;
      fetch_pend <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (wd_expired) begin
            state      <= ST_TRAP;
            cause      <= CAUSE_FETCH_TO;
            fetch_pend <= 1'b0;
          end else if (instr_we) begin
            state      <= ST_DECODE;
            fetch_pend <= 1'b0;
          end else begin
            // Keeps the request alive even if run drops mid-handshake.
            fetch_pend <= imem_req;
          end
        end
        ST_DECODE: begin
          if (illegal) begin
            state <= ST_TRAP;
            cause <= CAUSE_ILLEGAL;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state <= (is_load || is_store) ? ST_MEM : ST_WB;
        end
        ST_MEM: begin
          if (wd_expired) begin
            state <= ST_TRAP;
            cause <= CAUSE_DATA_TO;
          end else if (dmem_done) begin
            state <= is_store ? ST_FETCH : ST_WB;
          end
        end
        ST_WB: begin
          state <= ST_FETCH;
        end
        ST_TRAP: begin
          if (trap_clr) begin
            state <= ST_FETCH;
            cause <= CAUSE_NONE;
          end
        end
        default: begin
          state <= ST_FETCH;
          cause <= CAUSE_NONE;
        end
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (pc_we) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: a driver issues instructions, a model
// predicts each retire/trap event, and a monitor checks what the DUT presents.
module tb_core_sequencer;
  import core_pkg::*;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 64;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic             run, imem_ack, illegal, is_load, is_store, writes_rd;
  logic [4:0]       dest;
  logic             dmem_ack, trap_clr;
  logic             imem_req, instr_we, decode_en, exec_en, dmem_req, dmem_we;
  logic             rf_we, pc_we, trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;
  logic [2:0]       state_dbg;

  core_sequencer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .instr_we   (instr_we),
    .decode_en  (decode_en),
    .illegal    (illegal),
    .is_load    (is_load),
    .is_store   (is_store),
    .writes_rd  (writes_rd),
    .dest       (dest),
    .exec_en    (exec_en),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .rf_we      (rf_we),
    .pc_we      (pc_we),
    .trap       (trap),
    .trap_cause (trap_cause),
    .trap_clr   (trap_clr),
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model. Kinds: 0 alu, 1 load, 2 store, 3 illegal,
  // 4 fetch timeout, 5 data timeout. Event word:
  // {2'b0, trap, cause[1:0], rf_we seen, dmem_we seen, exec_en seen, latency[7:0]}
  // where latency counts cycles from the first imem_req cycle to the
  // pc_we cycle (or the first trap cycle), inclusive.
  function automatic logic [15:0] model(input int kind, input int fd, input int dd,
                                        input logic [4:0] d, input logic wr, input logic st);
    int         lat;
    logic       tr, rf, we, ex;
    logic [1:0] c;
    tr = 1'b0; c = 2'b00; rf = 1'b0; we = 1'b0; ex = 1'b1;
    case (kind)
      0: begin lat = (fd + 1) + 1 + 1 + 1;            rf = wr && (d != 5'd0); end
      1: begin lat = (fd + 1) + 1 + 1 + (dd + 1) + 1; rf = wr && (d != 5'd0); end
      2: begin lat = (fd + 1) + 1 + 1 + (dd + 1);     we = 1'b1; end
      3: begin lat = (fd + 1) + 1 + 1;                tr = 1'b1; c = 2'b11; ex = 1'b0; end
      4: begin lat = MEM_TIMEOUT + 1;                 tr = 1'b1; c = 2'b01; ex = 1'b0; end
      default: begin
        lat = (fd + 1) + 1 + 1 + MEM_TIMEOUT + 1;
        tr = 1'b1; c = 2'b10; we = st;
      end
    endcase
    return {2'b00, tr, c, rf, we, ex, lat[7:0]};
  endfunction

  // ---------------- monitor ----------------
  int          cyc;
  int          start_cyc;
  int          ret;
  logic        in_instr;
  logic        rf_s, we_s, ex_s;
  logic [15:0] obs;
  logic [15:0] exp_e;

  initial begin
    cyc = 0; ret = 0; in_instr = 1'b0; start_cyc = 0;
    rf_s = 1'b0; we_s = 1'b0; ex_s = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        in_instr = 1'b0;
        cyc      = 0;
        ret      = 0;
      end else begin
        cyc++;
        if (!in_instr && imem_req) begin
          in_instr  = 1'b1;
          start_cyc = cyc;
          rf_s = 1'b0; we_s = 1'b0; ex_s = 1'b0;
        end
        if (in_instr) begin
          rf_s = rf_s | rf_we;
          we_s = we_s | (dmem_req & dmem_we);
          ex_s = ex_s | exec_en;
          if (pc_we || trap) begin
            obs = {2'b00, trap, trap_cause, rf_s, we_s, ex_s, 8'(cyc - start_cyc + 1)};
            if (exp_q.size() == 0) begin
              check("event_unexpected", {48'd0, obs}, 64'd0);
            end else begin
              exp_e = exp_q.pop_front();
              check("event", {48'd0, obs}, {48'd0, exp_e});
            end
`ifdef SEQ_PERF_CNT_EN
            check("cycle_cnt", cycle_cnt, 64'(cyc - 1));
            check("instret_cnt", instret_cnt, 64'(ret));
`else
            check("cycle_cnt_tied", cycle_cnt, 64'd0);
            check("instret_cnt_tied", instret_cnt, 64'd0);
`endif
            if (!trap) ret++;
            in_instr = 1'b0;
            done_cnt++;
          end
        end else if (pc_we) begin
          check("stray_pc_we", 64'd1, 64'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_req_ack(input bit data, input int delay, input bit no_ack);
    int n = 0;
    #1;
    while (!(data ? dmem_req : imem_req)) begin
      if (n++ >= 40) begin
        check(data ? "dmem_req_wait" : "imem_req_wait", 64'd0, 64'd1);
        return;
      end
      @(negedge clk);
      #1;
    end
    if (no_ack) return;
    repeat (delay) begin
      @(negedge clk);
      if (data) imem_ack = 1'($urandom_range(0, 1));
      else      dmem_ack = 1'($urandom_range(0, 1));
    end
    if (data) begin dmem_ack = 1'b1; imem_ack = 1'b0; end
    else      begin imem_ack = 1'b1; dmem_ack = 1'b0; end
    @(negedge clk);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int n = 0;
    while (done_cnt == prev) begin
      if (n++ >= 200) begin
        check("event_wait", 64'd0, 64'd1);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_instr(input int kind, input int fd, input int dd,
                           input logic [4:0] d, input logic wr, input logic st);
    int   prev;
    logic [1:0] cause_exp;
    // idle in FETCH with run low; stray trap_clr must be ignored here
    repeat ($urandom_range(0, 2)) begin
      trap_clr = 1'($urandom_range(0, 1));
      #1 check("run0_no_req", {63'd0, imem_req}, 64'd0);
      @(negedge clk);
    end
    trap_clr  = 1'b0;
    illegal   = (kind == 3);
    is_load   = (kind == 1) || (kind == 5 && !st);
    is_store  = (kind == 2) || (kind == 5 && st);
    writes_rd = wr;
    dest      = d;
    prev      = done_cnt;
    exp_q.push_back(model(kind, fd, dd, d, wr, st));
    run = 1'b1;
    if (kind != 4) begin
      wait_req_ack(1'b0, fd, 1'b0);
      run = 1'b0;
      if (kind == 1 || kind == 2) wait_req_ack(1'b1, dd, 1'b0);
      if (kind == 5) wait_req_ack(1'b1, 0, 1'b1);
    end
    wait_done(prev);
    if (kind >= 3) begin
      cause_exp = (kind == 3) ? 2'b11 : (kind == 4) ? 2'b01 : 2'b10;
      check("trap_sticky", {60'd0, trap, trap_cause, imem_req | dmem_req},
            {60'd0, 1'b1, cause_exp, 1'b0});
      run      = 1'b0;
      trap_clr = 1'b1;
      @(negedge clk);
      trap_clr = 1'b0;
      #1 check("trap_exit", {61'd0, trap, trap_cause}, 64'd0);
      @(negedge clk);
    end
  endtask

  task automatic reset_mid_dmem();
    illegal = 1'b0; is_load = 1'b1; is_store = 1'b0; writes_rd = 1'b1; dest = 5'd5;
    run = 1'b1;
    wait_req_ack(1'b0, 0, 1'b0);
    run = 1'b0;
    wait_req_ack(1'b1, 0, 1'b1);
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    check("reset_mid_outputs",
          {52'd0, imem_req, instr_we, decode_en, exec_en, dmem_req, dmem_we,
           rf_we, pc_we, trap, trap_cause, 1'b0}, 64'd0);
    check("reset_mid_cycle_cnt", cycle_cnt, 64'd0);
    check("reset_mid_instret", instret_cnt, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_release_state", {61'd0, state_dbg}, {61'd0, ST_FETCH});
    check("reset_release_counters", cycle_cnt | instret_cnt, 64'd0);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int kind;
    logic [4:0] d;
    logic wr, st;
    reset = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; trap_clr = 1'b0;
    illegal = 1'b0; is_load = 1'b0; is_store = 1'b0; writes_rd = 1'b0; dest = 5'd0;
    repeat (2) @(negedge clk);
    run = 1'b1;
    #1;
    check("reset_outputs",
          {52'd0, imem_req, instr_we, decode_en, exec_en, dmem_req, dmem_we,
           rf_we, pc_we, trap, trap_cause, 1'b0}, 64'd0);
    check("reset_counters", cycle_cnt | instret_cnt, 64'd0);
    run   = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    run_instr(0, 0, 0, 5'd3, 1'b1, 1'b0);
    run_instr(1, 0, 3, 5'd5, 1'b1, 1'b0);
    run_instr(2, 0, 1, 5'd7, 1'b0, 1'b0);
    run_instr(0, 1, 0, 5'd0, 1'b1, 1'b0);
    run_instr(0, MEM_TIMEOUT - 1, 0, 5'd9, 1'b1, 1'b0);
    run_instr(4, 0, 0, 5'd0, 1'b0, 1'b0);
    run_instr(3, 2, 0, 5'd4, 1'b1, 1'b0);
    run_instr(5, 0, 0, 5'd0, 1'b0, 1'b1);
    run_instr(1, 0, MEM_TIMEOUT - 1, 5'd12, 1'b1, 1'b0);
    reset_mid_dmem();
    run_instr(0, 0, 0, 5'd1, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      kind = (kind <= 2) ? 0 : (kind <= 4) ? 1 : (kind <= 6) ? 2 : kind - 4;
      d    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wr   = (kind == 1) ? 1'b1 : (kind == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      st   = 1'($urandom_range(0, 1));
      run_instr(kind, $urandom_range(0, 4), $urandom_range(0, 4), d, wr, st);
    end

    repeat (3) @(negedge clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    n_checks++;
    n_fail++;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "simulation time limit reached");
  end

endmodule
